// File: rtl/sequenciador_execucao_if.sv
`default_nettype none
// ============================================================================
// Module      : sequenciador_execucao_if
// Description : Qualifier / strobe / latch bundle between the control unit
//               (master) and the execution sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sequenciador_execucao_if #(
    parameter int CNT_W = 32,
    parameter int IO_W  = 16
);
    // Qualifiers and data coming from the decoder / datapath
    logic             delay_req_i;
    logic             entrada_req_i;
    logic             saida_req_i;
    logic             muldiv_req_i;
    logic             esc_reg_req_i;
    logic             esc_mem_req_i;
    logic [CNT_W-1:0] delay_val_i;
    logic             confirma_i;
    logic [IO_W-1:0]  in_data_i;
    logic [IO_W-1:0]  out_src_i;
    logic             md_done_i;

    // Strobes, latches and status driven by the sequencer
    logic             ir_load_o;
    logic             pc_en_o;
    logic             reg_we_o;
    logic             mem_we_o;
    logic             md_start_o;
    logic [IO_W-1:0]  in_q_o;
    logic [IO_W-1:0]  out_q_o;
    logic             aguardando_o;
    logic             md_erro_o;
    logic [2:0]       estado_o;

    modport master (
        output delay_req_i, entrada_req_i, saida_req_i, muldiv_req_i,
               esc_reg_req_i, esc_mem_req_i, delay_val_i, confirma_i,
               in_data_i, out_src_i, md_done_i,
        input  ir_load_o, pc_en_o, reg_we_o, mem_we_o, md_start_o,
               in_q_o, out_q_o, aguardando_o, md_erro_o, estado_o
    );

    modport slave (
        input  delay_req_i, entrada_req_i, saida_req_i, muldiv_req_i,
               esc_reg_req_i, esc_mem_req_i, delay_val_i, confirma_i,
               in_data_i, out_src_i, md_done_i,
        output ir_load_o, pc_en_o, reg_we_o, mem_we_o, md_start_o,
               in_q_o, out_q_o, aguardando_o, md_erro_o, estado_o
    );
endinterface
`default_nettype wire

// File: rtl/sequenciador_execucao.sv
`default_nettype none
// ============================================================================
// Module      : sequenciador_execucao
// Description : Multi-cycle execution sequencer. Fetch/commit strobes, timed
//               delay stall, user-confirmed input stall, mul/div stall with
//               timeout, and the input/output latches.
// Revision    : 1.0 - initial release
// ============================================================================
module sequenciador_execucao #(
    parameter int CNT_W      = 32,
    parameter int PRESCALE   = 50000,
    parameter int IO_W       = 16,
    parameter int MD_TIMEOUT = 64
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    sequenciador_execucao_if.slave  bus
);

    localparam int c_PRE_W = $clog2(PRESCALE + 1);
    localparam int c_TMO_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [c_PRE_W-1:0] c_PRE_RELOAD = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(MD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_EXEC    = 3'd1,
        S_DELAY   = 3'd2,
        S_WAIT_IN = 3'd3,
        S_WAIT_MD = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [c_PRE_W-1:0] pre_q, pre_d;
    logic [c_TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]         sync_q;
    logic [IO_W-1:0]    in_q, out_q;
    logic               md_erro_q;

    logic w_commit, w_ir_load, w_md_start, w_capture_in, w_set_err, w_edge;

    // Two synchronizer stages plus one history stage for edge detection
    assign w_edge = sync_q[1] & ~sync_q[2];

    // State, stall counters and confirm synchronizer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            rem_q   <= '0;
            pre_q   <= '0;
            tmo_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pre_q   <= pre_d;
            tmo_q   <= tmo_d;
            sync_q  <= {sync_q[1:0], bus.confirma_i};
        end
    end

    // Next-state and strobe decode; every path that retires goes back to FETCH
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pre_d        = pre_q;
        tmo_d        = tmo_q;
        w_commit     = 1'b0;
        w_ir_load    = 1'b0;
        w_md_start   = 1'b0;
        w_capture_in = 1'b0;
        w_set_err    = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_ir_load = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (bus.delay_req_i) begin
                    if (bus.delay_val_i == '0) begin
                        w_commit = 1'b1;
                    end else begin
                        rem_d   = bus.delay_val_i;
                        pre_d   = c_PRE_RELOAD;
                        state_d = S_DELAY;
                    end
                end else if (bus.entrada_req_i) begin
                    state_d = S_WAIT_IN;
                end else if (bus.muldiv_req_i) begin
                    w_md_start = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_WAIT_MD;
                end else begin
                    w_commit = 1'b1;
                end
            end
            S_DELAY: begin
                if (pre_q == '0) begin
                    if (rem_q == CNT_W'(1)) begin
                        w_commit = 1'b1;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                        pre_d = c_PRE_RELOAD;
                    end
                end else begin
                    pre_d = pre_q - c_PRE_W'(1);
                end
            end
            S_WAIT_IN: begin
                if (w_edge) begin
                    w_capture_in = 1'b1;
                    w_commit     = 1'b1;
                end
            end
            S_WAIT_MD: begin
                if (bus.md_done_i) begin
                    w_commit = 1'b1;
                end else if (tmo_q == c_TMO_LAST) begin
                    w_set_err = 1'b1;
                    w_commit  = 1'b1;
                end else begin
                    tmo_d = tmo_q + c_TMO_W'(1);
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (w_commit) begin
            state_d = S_FETCH;
        end
    end

    // Input/output latches and the sticky mul/div timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q      <= '0;
            out_q     <= '0;
            md_erro_q <= 1'b0;
        end else begin
            if (w_capture_in) begin
                in_q <= bus.in_data_i;
            end
            if (w_commit && bus.saida_req_i) begin
                out_q <= bus.out_src_i;
            end
            if (w_set_err) begin
                md_erro_q <= 1'b1;
            end
        end
    end

    // Strobes are masked while reset is held so FETCH does not pulse ir_load
    assign bus.ir_load_o    = w_ir_load  & reset_n;
    assign bus.pc_en_o      = w_commit   & reset_n;
    assign bus.reg_we_o     = w_commit   & bus.esc_reg_req_i & reset_n;
    assign bus.mem_we_o     = w_commit   & bus.esc_mem_req_i & reset_n;
    assign bus.md_start_o   = w_md_start & reset_n;
    assign bus.in_q_o       = in_q;
    assign bus.out_q_o      = out_q;
    assign bus.md_erro_o    = md_erro_q;
    assign bus.aguardando_o = (state_q == S_WAIT_IN);
    assign bus.estado_o     = state_q;

endmodule
`default_nettype wire
